// File: rtl/div_unit_pkg.sv
// Shared divider definitions: state encoding and handshake constants.
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_t;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/div_unit_step.sv
// One restoring division step: shift in the next dividend bit, trial
// subtract the divisor, keep the difference only when it is non-negative.
module div_unit_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem,
  input  logic              dvd_bit,
  input  logic [DATA_W-1:0] dvs,
  output logic [DATA_W:0]   rem_next,
  output logic              q_bit
);

  logic [DATA_W+1:0]        shifted;
  logic signed [DATA_W+1:0] diff;

  // Trial subtraction; one extra bit keeps the sign of the difference visible.
  always_comb begin
    shifted = {rem, dvd_bit};
    diff    = $signed(shifted) - $signed({2'b00, dvs});
    if (diff < 0) begin
      rem_next = shifted[DATA_W:0];
      q_bit    = 1'b0;
    end else begin
      rem_next = diff[DATA_W:0];
      q_bit    = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (DIV / DIVU) for the execute stage.
// Answers the hazard unit's start with a one-cycle ready pulse and returns
// {remainder, quotient} for the HI/LO write path.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_div,
  input  logic                annul,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);

  div_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd_p0;
  logic [DATA_W-1:0] dvs_p0;
  logic [DATA_W:0]   rem_p0;
  logic [DATA_W-1:0] quo_p0;
  logic              neg_q_p0;
  logic              neg_r_p0;

  logic [DATA_W:0]   rem_next;
  logic              q_bit;
  logic [DATA_W-1:0] quo_final;

  // Magnitude of an operand; only signed operands with the MSB set are negated.
  function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v,
                                                input logic              sgn);
    return (sgn && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

  // Two's-complement sign correction of an unsigned magnitude result.
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  div_unit_step #(.DATA_W(DATA_W)) u_step (
    .rem      (rem_p0),
    .dvd_bit  (dvd_p0[DATA_W-1]),
    .dvs      (dvs_p0),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_final = {quo_p0[DATA_W-2:0], q_bit};

  // Divider FSM: operand capture, iteration, sign correction and ready pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      dvd_p0   <= '0;
      dvs_p0   <= '0;
      rem_p0   <= '0;
      quo_p0   <= '0;
      neg_q_p0 <= 1'b0;
      neg_r_p0 <= 1'b0;
      result   <= '0;
      ready    <= DIV_RESULT_NOT_READY;
    end else begin
      ready <= DIV_RESULT_NOT_READY;
      if (annul) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          // Capture stage: operands reduced to magnitudes, signs remembered.
          DIV_IDLE: begin
            if (start == DIV_START) begin
              dvd_p0   <= abs_val(opdata1, signed_div);
              dvs_p0   <= abs_val(opdata2, signed_div);
              rem_p0   <= '0;
              quo_p0   <= '0;
              cnt      <= '0;
              neg_q_p0 <= signed_div & (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
              neg_r_p0 <= signed_div & opdata1[DATA_W-1];
              state    <= (opdata2 == '0) ? DIV_BYZERO : DIV_ON;
            end
          end
          DIV_BYZERO: begin
            result <= '0;
            ready  <= DIV_RESULT_READY;
            state  <= DIV_END;
          end
          // Iteration stage: one quotient bit per cycle, MSB first.
          DIV_ON: begin
            rem_p0 <= rem_next;
            quo_p0 <= quo_final;
            dvd_p0 <= {dvd_p0[DATA_W-2:0], 1'b0};
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(DATA_W - 1)) begin
              result <= {cond_neg(rem_next[DATA_W-1:0], neg_r_p0),
                         cond_neg(quo_final, neg_q_p0)};
              ready  <= DIV_RESULT_READY;
              state  <= DIV_END;
            end
          end
          DIV_END: begin
            state <= DIV_IDLE;
          end
          default: begin
            state <= DIV_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_unit;
  import div_unit_pkg::*;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic           signed_div;
  logic           annul;
  logic [W-1:0]   opdata1;
  logic [W-1:0]   opdata2;
  logic [2*W-1:0] result;
  logic           ready;

  int checks;
  int errors;
  logic [2*W-1:0] exp_last;

  div_unit #(.DATA_W(W), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .result     (result),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: plain 64-bit integer division, C-style truncation.
  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input bit           sgn);
    longint sa, sb, q, r;
    if (b == 0) return '0;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic int ref_lat(input logic [W-1:0] b);
    return (b == 0) ? 2 : W + 1;
  endfunction

  // Issue one divide like the hazard unit does; operand buses are scrambled
  // after the start edge. Returns cycles from start edge to ready (0 = none).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit sgn, output int lat);
    @(negedge clk);
    start      = DIV_START;
    signed_div = sgn;
    opdata1    = a;
    opdata2    = b;
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (ready) begin
        lat = n;
        break;
      end
      opdata1 = $urandom;
      opdata2 = $urandom;
    end
    start = DIV_STOP;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = DIV_STOP; annul = 1'b0; signed_div = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL reset_result: got %h expected %h", result, 64'h0);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b expected 0", ready);
    end
    rst = 1'b1;
    exp_last = '0;
  endtask

  task automatic test_unsigned();
    int lat;
    logic [2*W-1:0] exp;
    run_div(32'd100, 32'd7, 1'b0, lat);
    exp = {32'd2, 32'd14};
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL divu_latency: got %0d expected %0d", lat, 33);
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL divu_result: got %h expected %h", result, exp);
    end
    exp_last = exp;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL divu_ready_pulse: got %b expected 0", ready);
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [2*W-1:0] exp;
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, lat);
    exp = {32'hFFFFFFFF, 32'hFFFFFFFD};
    checks++;
    if (result !== exp || lat !== 33) begin
      errors++; $display("FAIL div_signed: got %h lat %0d expected %h lat 33", result, lat, exp);
    end
    exp_last = exp;
  endtask

  task automatic test_overflow();
    int lat;
    logic [2*W-1:0] exp;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
    exp = {32'h0, 32'h80000000};
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL div_intmin: got %h expected %h", result, exp);
    end
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL div_intmin_latency: got %0d expected 33", lat);
    end
    exp_last = exp;
  endtask

  task automatic test_div_zero();
    int lat;
    run_div(32'd123, 32'd0, 1'b0, lat);
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL divzero_latency: got %0d expected 2", lat);
    end
    checks++;
    if (result !== 64'h0) begin
      errors++; $display("FAIL divzero_result: got %h expected %h", result, 64'h0);
    end
    exp_last = '0;
    // Leave a nonzero result so the annul test can see it held.
    run_div(32'd1000, 32'd9, 1'b0, lat);
    exp_last = ref_div(32'd1000, 32'd9, 1'b0);
    checks++;
    if (result !== exp_last) begin
      errors++; $display("FAIL divu_after_zero: got %h expected %h", result, exp_last);
    end
  endtask

  task automatic test_annul();
    int lat;
    bit seen;
    logic [2*W-1:0] exp;
    seen = 1'b0;
    @(negedge clk);
    start = DIV_START; signed_div = 1'b0; opdata1 = 32'd5000; opdata2 = 32'd3;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    annul = 1'b1;
    start = DIV_STOP;
    @(negedge clk);
    annul = 1'b0;
    checks++;
    if (seen || ready !== 1'b0) begin
      errors++; $display("FAIL annul_no_ready: got %b expected 0", seen | ready);
    end
    checks++;
    if (result !== exp_last) begin
      errors++; $display("FAIL annul_result_held: got %h expected %h", result, exp_last);
    end
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, lat);
    exp = {32'hF, 32'h0FFFFFFF};
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL annul_restart_latency: got %0d expected 33", lat);
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL annul_restart_result: got %h expected %h", result, exp);
    end
    exp_last = exp;
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [2*W-1:0] exp;
    run_div(32'd999999, 32'd1000, 1'b0, lat);
    exp = ref_div(32'd999999, 32'd1000, 1'b0);
    checks++;
    if (result !== exp || lat !== 33) begin
      errors++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 33", result, lat, exp);
    end
    // Next start issued on the very next cycle after the ready pulse.
    run_div(32'hFFFF8000, 32'h00000100, 1'b1, lat);
    exp = ref_div(32'hFFFF8000, 32'h00000100, 1'b1);
    checks++;
    if (lat !== 33) begin
      errors++; $display("FAIL b2b_second_latency: got %0d expected 33", lat);
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL b2b_second_result: got %h expected %h", result, exp);
    end
    exp_last = exp;
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] a, b;
    bit sgn;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom >> $urandom_range(0, 31);
      sgn = $urandom_range(0, 1);
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h80000000;
        2: b = 32'hFFFFFFFF;
        3: a = b;
        default: ;
      endcase
      run_div(a, b, sgn, lat);
      exp = ref_div(a, b, sgn);
      checks++;
      if (result !== exp) begin
        errors++; $display("FAIL rand_result[%0d] %h/%h s=%0d: got %h expected %h", i, a, b, sgn, result, exp);
      end
      checks++;
      if (lat !== ref_lat(b)) begin
        errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, ref_lat(b));
      end
      exp_last = exp;
    end
  endtask

  task automatic test_async_reset();
    int lat;
    bit seen;
    logic [2*W-1:0] exp;
    run_div(32'd77777, 32'd13, 1'b0, lat);
    exp_last = ref_div(32'd77777, 32'd13, 1'b0);
    checks++;
    if (result !== exp_last) begin
      errors++; $display("FAIL pre_reset_result: got %h expected %h", result, exp_last);
    end
    @(negedge clk);
    start = DIV_START; opdata1 = 32'd4242; opdata2 = 32'd5;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL async_reset_result: got %h expected %h", result, 64'h0);
    end
    checks++;
    if (ready !== 1'b0) begin
      errors++; $display("FAIL async_reset_ready: got %b expected 0", ready);
    end
    start = DIV_STOP;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ready || result !== '0) seen = 1'b1;
    end
    rst = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (ready) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL async_reset_abort: got activity 1 expected 0");
    end
    run_div(32'hFFFFFF9C, 32'd7, 1'b1, lat);
    exp = ref_div(32'hFFFFFF9C, 32'd7, 1'b1);
    checks++;
    if (result !== exp || lat !== 33) begin
      errors++; $display("FAIL post_reset_div: got %h lat %0d expected %h lat 33", result, lat, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider, signed (DIV) and unsigned (DIVU), located in the execute stage.
- It is the responder to the hazard unit's divide handshake:
  - consumes div_start (plus operands and signedness from E stage);
  - returns div_ready, which releases the E-stage stall.
- Result is {remainder, quotient}, written to HI/LO through the normal hilo write path.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are DATA_W each; result is 2*DATA_W.
- CNT_W, 6, iteration counter width. Must hold DATA_W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  div_start from hazard unit; high while a div op sits in E and ready=0
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU
- annul  input  1  abort in-flight operation (exception/flush); return to IDLE
- opdata1  input  DATA_W  dividend (rs value, forwarded)
- opdata2  input  DATA_W  divisor (rt value, forwarded)
- result  output  2*DATA_W  {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}; HI = remainder, LO = quotient
- ready  output  1  div_ready to hazard unit; single-cycle pulse when result valid

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, result=0, ready=0, all internal datapath regs=0.
- States and transitions:
  - IDLE: on start=1 & annul=0:
    - latch operands and signedness;
    - go to BYZERO if opdata2==0, else ON with cnt=0.
    - start=0 → stay in IDLE.
  - BYZERO: next cycle → END with result=0 (quotient=0, remainder=0); this is the decided value.
  - ON: one shift/subtract step per cycle, cnt increments.
    - When cnt reaches DATA_W-1, the final step completes and the state goes to END.
    - Exactly DATA_W cycles are spent in ON.
  - END:
    - ready=1 for this cycle only; result register loaded with the sign-corrected value.
    - Unconditionally → IDLE.
- Handshake:
  - Hazard drives start = div_op & ~ready, so start falls in END combinationally.
  - The pipeline advances at the END clock edge.
  - A back-to-back div in E then sees start=1 in IDLE and begins fresh.
- Latency: start sampled in IDLE at edge t → ready high during cycle t+DATA_W+1 (33 for DATA_W=32); division by zero → ready at t+2.
- Operands are latched at the start edge only. Changes on opdata1/opdata2 during ON are ignored.
- Signed arithmetic:
  - Divide magnitudes (two's-complement negate if MSB set and signed_div=1).
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Magnitudes are DATA_W-bit unsigned; the INT_MIN magnitude is representable as unsigned.
  - INT_MIN / -1 → quotient 0x80000000 (wraps), remainder 0. No trap.
- Unsigned: no sign correction.
- Step datapath:
  - Partial remainder is DATA_W+1 bits; each step shifts in the next dividend bit.
  - Trial subtract of the divisor; if non-negative, keep the difference and shift 1 into the quotient, else shift 0.
- annul=1 in any state → next state IDLE, ready=0, result unchanged. annul has priority over start and over END completion.
- result holds its last value until the next END; it is not cleared on IDLE.
- Reset mid-operation aborts immediately. No partial result is visible.
- start deasserted during ON or BYZERO (without annul): the operation continues to END. The ready pulse is still produced, and the hazard unit ignores it.

Decomposition:
- Shared defines (existing defines file):
  - state encodings DIV_IDLE=2'b00, DIV_BYZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11;
  - DivResultReady/DivResultNotReady, DivStart/DivStop constants.
  - EXE_DIV_OP / EXE_DIVU_OP already live there.
- One combinational sub-module, div_step (one restoring step: partial remainder, divisor → next remainder, quotient bit), is natural. Everything else stays in div_unit.

Test Plan:
- Unsigned: start=1, signed_div=0, opdata1=100, opdata2=7 → ready pulse exactly 33 cycles after the start edge; result={32'd2, 32'd14}; ready low the following cycle.
- Signed: opdata1=-7 (0xFFFFFFF9), opdata2=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Overflow case: signed, opdata1=0x80000000, opdata2=0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Divide by zero: opdata2=0, opdata1=123 → ready 2 cycles after start; result=64'h0.
- Abort and back-to-back:
  - annul=1 at cycle 10 of ON → IDLE next cycle, no ready pulse, result keeps its prior value.
  - A new start in the following cycle (DIVU 0xFFFFFFFF / 0x10) → result={32'hF, 32'h0FFFFFFF}.
  - A second div issued immediately after ready → second start accepted in IDLE the next cycle and completes correctly.
- Async reset: assert rst=0 mid-ON between clock edges → state IDLE, ready=0, result=0 immediately, without waiting for a clock edge.
